// File: rtl/rect_prog_pkg.sv
// Shared definitions for the rectangle-renderer chain: register map, field and
// chain bus widths, master FSM states.
package rect_prog_pkg;
  localparam int NUM_REGS   = 5;
  localparam int REG_XCOORD = 0;
  localparam int REG_YCOORD = 1;
  localparam int REG_WIDTH  = 2;
  localparam int REG_HEIGHT = 3;
  localparam int REG_COLOR  = 4;

  localparam int XCOORD_W = 12;
  localparam int YCOORD_W = 13;
  localparam int WIDTH_W  = 12;
  localparam int HEIGHT_W = 13;
  localparam int COLOR_W  = 32;

  localparam int X_W   = 11;
  localparam int Y_W   = 12;
  localparam int D_W   = 32;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, SEND} state_t;

  // Lowest set bit of a register mask; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_REGS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i]) r = IDX_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/rect_program_master.sv
// Head-of-chain initiator: serialises shape commands into program beats during
// blanking and forwards pixels otherwise. Optional macro: RECT_PARTIAL_UPDATE_EN.
module rect_program_master
  import rect_prog_pkg::*;
#(
  parameter int NUM_SHAPES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  input  logic [D_W-1:0]      pix_data,
  input  logic                blank_in,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_shape_id,
  input  logic [XCOORD_W-1:0] cmd_xcoord,
  input  logic [YCOORD_W-1:0] cmd_ycoord,
  input  logic [WIDTH_W-1:0]  cmd_width,
  input  logic [HEIGHT_W-1:0] cmd_height,
  input  logic [COLOR_W-1:0]  cmd_color,
`ifdef RECT_PARTIAL_UPDATE_EN
  input  logic [NUM_REGS-1:0] cmd_mask,
`endif
  output logic                program_out,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [D_W-1:0]      data_out,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_t               state;
  logic [X_W-1:0]       shape_q;
  logic [XCOORD_W-1:0]  xcoord_q;
  logic [YCOORD_W-1:0]  ycoord_q;
  logic [WIDTH_W-1:0]   width_q;
  logic [HEIGHT_W-1:0]  height_q;
  logic [COLOR_W-1:0]   color_q;
  // Registers still to send; the lowest set bit is the current reg_idx.
  logic [NUM_REGS-1:0]  pend;
  logic [NUM_REGS-1:0]  pend_next;
  logic [NUM_REGS-1:0]  mask_in;
  logic [IDX_W-1:0]     idx;
  logic [D_W-1:0]       field;
  logic                 accept;
  logic                 id_ok;

`ifdef RECT_PARTIAL_UPDATE_EN
  assign mask_in = cmd_mask;
`else
  assign mask_in = '1;
`endif

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state == SEND);
  assign accept    = cmd_valid && cmd_ready;
  assign id_ok     = int'(cmd_shape_id) < NUM_SHAPES;
  assign idx       = first_set(pend);
  assign pend_next = pend & ~(NUM_REGS'(1) << idx);

  always_comb begin
    field = '0;
    case (int'(idx))
      REG_XCOORD: field = D_W'(xcoord_q);
      REG_YCOORD: field = D_W'(ycoord_q);
      REG_WIDTH:  field = D_W'(width_q);
      REG_HEIGHT: field = D_W'(height_q);
      default:    field = D_W'(color_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shape_q     <= '0;
      xcoord_q    <= '0;
      ycoord_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      color_q     <= '0;
      pend        <= '0;
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      program_out <= 1'b0;
      x_out       <= pix_x;
      y_out       <= pix_y;
      data_out    <= pix_data;
      case (state)
        IDLE: if (accept) begin
          shape_q  <= cmd_shape_id;
          xcoord_q <= cmd_xcoord;
          ycoord_q <= cmd_ycoord;
          width_q  <= cmd_width;
          height_q <= cmd_height;
          color_q  <= cmd_color;
          pend     <= mask_in;
          if (!id_ok)            err   <= 1'b1;
          else if (mask_in == '0) done <= 1'b1;
          else                    state <= SEND;
        end
        SEND: if (blank_in) begin
          program_out <= 1'b1;
          x_out       <= shape_q;
          y_out       <= Y_W'(idx);
          data_out    <= field;
          pend        <= pend_next;
          if (pend_next == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_program_master.sv
// Scoreboard bench for rect_program_master: stimulus queues expected program
// beats, a negedge monitor pops and compares each beat the DUT presents.
module tb_rect_program_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pix_x;
  logic [11:0] pix_y;
  logic [31:0] pix_data;
  logic        blank_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_shape_id;
  logic [11:0] cmd_xcoord;
  logic [12:0] cmd_ycoord;
  logic [11:0] cmd_width;
  logic [12:0] cmd_height;
  logic [31:0] cmd_color;
`ifdef RECT_PARTIAL_UPDATE_EN
  logic [4:0]  cmd_mask;
`endif
  logic        program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] x;
    logic [11:0] y;
    logic [31:0] d;
    logic        dn;
  } beat_t;
  beat_t exp_q[$];

  rect_program_master #(.NUM_SHAPES(16)) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .blank_in(blank_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape_id(cmd_shape_id), .cmd_xcoord(cmd_xcoord), .cmd_ycoord(cmd_ycoord),
    .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_color(cmd_color),
`ifdef RECT_PARTIAL_UPDATE_EN
    .cmd_mask(cmd_mask),
`endif
    .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] x, input logic [11:0] y, input logic [31:0] d,
                      input logic dn);
    beat_t b;
    b.x = x; b.y = y; b.d = d; b.dn = dn;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [10:0] id, input logic [11:0] xc, input logic [12:0] yc,
                         input logic [11:0] w, input logic [12:0] h, input logic [31:0] c);
    cmd_shape_id = id; cmd_xcoord = xc; cmd_ycoord = yc;
    cmd_width = w; cmd_height = h; cmd_color = c;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: every program beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && program_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_y", y_out, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_x", x_out, e.x);
        chk("beat_y", y_out, e.y);
        chk("beat_data", data_out, e.d);
        chk("beat_done", done, e.dn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; blank_in = 1'b0; cmd_valid = 1'b0;
    pix_x = 11'd1; pix_y = 12'd2; pix_data = 32'h3;
    set_cmd(0, 0, 0, 0, 0, 0);
`ifdef RECT_PARTIAL_UPDATE_EN
    cmd_mask = 5'b11111;
`endif
    #3;
    chk("rst_program", program_out, 0);
    chk("rst_x", x_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    // Passthrough in IDLE
    pix_x = 11'd640; pix_y = 12'd480; pix_data = 32'h12345678;
    tick();
    chk("pass_program", program_out, 0);
    chk("pass_x", x_out, 640);
    chk("pass_y", y_out, 480);
    chk("pass_data", data_out, 32'h12345678);

    // Full record with blank held high
    blank_in = 1'b1;
    push(3, 0, 100, 0); push(3, 1, 50, 0); push(3, 2, 20, 0);
    push(3, 3, 10, 0); push(3, 4, 32'hFF00FF00, 1);
    set_cmd(3, 100, 50, 20, 10, 32'hFF00FF00);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("full_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_ready_low", cmd_ready, 0);
    end
    tick();
    chk("full_idle_after", busy, 0);
    drain();

    // Stall: blank 1,1,0,0,0,1,1,1 after acceptance
    push(5, 0, 1, 0); push(5, 1, 2, 0); push(5, 2, 3, 0);
    push(5, 3, 4, 0); push(5, 4, 32'h00C0FFEE, 1);
    set_cmd(5, 1, 2, 3, 4, 32'h00C0FFEE);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    blank_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pix_x = 11'(10 + k); pix_y = 12'(20 + k); pix_data = 32'hD0 + 32'(k);
      tick();
      chk("stall_program", program_out, 0);
      chk("stall_x", x_out, 10 + k);
      chk("stall_y", y_out, 20 + k);
      chk("stall_data", data_out, 32'hD0 + 32'(k));
      chk("stall_busy", busy, 1);
    end
    blank_in = 1'b1;
    tick(); tick(); tick();
    drain();

    // Reject: ID equal to NUM_SHAPES
    set_cmd(16, 9, 9, 9, 9, 9);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_ready", cmd_ready, 1);
    tick();
    chk("rej_err_pulse", err, 0);
    repeat (4) tick();
    chk("rej_no_beats", exp_q.size(), 0);

    // Back-to-back; fields changed after acceptance must not affect record A
    push(1, 0, 11, 0); push(1, 1, 12, 0); push(1, 2, 13, 0);
    push(1, 3, 14, 0); push(1, 4, 32'hA1, 1);
    push(15, 0, 21, 0); push(15, 1, 22, 0); push(15, 2, 23, 0);
    push(15, 3, 24, 0); push(15, 4, 32'hB2, 1);
    set_cmd(1, 11, 12, 13, 14, 32'hA1);
    cmd_valid = 1'b1;
    tick();
    set_cmd(15, 21, 22, 23, 24, 32'hB2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_ready_low", cmd_ready, 0);
    end
    tick();
    chk("b2b_ready_after_color", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    drain();

    // Reset mid-record after beat reg 1
    push(2, 0, 1, 0); push(2, 1, 2, 0);
    set_cmd(2, 1, 2, 3, 4, 5);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_program", program_out, 0);
    chk("mid_rst_y", y_out, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_idle_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (8) tick();
    chk("mid_rst_no_beats", exp_q.size(), 0);

`ifdef RECT_PARTIAL_UPDATE_EN
    // Partial update: registers 0 and 4 only, back-to-back
    push(4, 0, 100, 0); push(4, 4, 32'hFF00FF00, 1);
    set_cmd(4, 100, 50, 20, 10, 32'hFF00FF00);
    cmd_mask = 5'b10001;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("part_idle", busy, 0);
    chk("part_beats", exp_q.size(), 0);
    drain();
    // Empty mask: done one cycle after acceptance, no beats
    cmd_mask = 5'b00000;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("mask0_done", done, 1);
    chk("mask0_busy", busy, 0);
    tick();
    chk("mask0_done_pulse", done, 0);
    repeat (4) tick();
    chk("mask0_no_beats", exp_q.size(), 0);
    cmd_mask = 5'b11111;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
